// File: rtl/vlane_mem_port.sv
// Per-lane load/store port: turns one-cycle issue requests into a single-outstanding memory request.
// Latency: request -> mem_req_valid +1; best-case load read_done +3, store store_done +2 (all outputs registered).
// Backpressure: port_ready is low outside IDLE; mem_req_valid/addr/we/wdata hold until mem_req_ready.
module vlane_mem_port #(
    parameter int LANES_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wait_load_signal,
    input  logic                        store_request,
    input  logic [4:0]                  load_destination,
    input  logic [LANES_DATA_WIDTH-1:0] wrdata,
    input  logic [LANES_DATA_WIDTH-1:0] indexed,
    input  logic [ADDR_WIDTH-1:0]       base_address,
    output logic                        port_ready,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_we,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    output logic [LANES_DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                        mem_rsp_valid,
    input  logic [LANES_DATA_WIDTH-1:0] mem_rsp_rdata,
    output logic                        read_done,
    output logic [4:0]                  load_data_destination,
    output logic [LANES_DATA_WIDTH-1:0] data_from_load,
    output logic                        store_done,
    output logic                        timeout_error
);

    // Wide enough to hold TIMEOUT_CYCLES itself so the counter can saturate there.
    localparam int                CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state;
    logic [4:0]            dest_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic [ADDR_WIDTH-1:0] req_addr;

    // Only the low ADDR_WIDTH bits of the index offset take part; carry-out is dropped.
    assign req_addr = base_address + indexed[ADDR_WIDTH-1:0];

    // Upper index bits never reach the address; fold them into a sink so intent is explicit.
    if (LANES_DATA_WIDTH > ADDR_WIDTH) begin : g_idx_hi
        logic unused_idx_hi;
        assign unused_idx_hi = ^indexed[LANES_DATA_WIDTH-1:ADDR_WIDTH];
    end

    // Port FSM with registered outputs; pulses default low and are raised for one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                 <= S_IDLE;
            port_ready            <= 1'b1;
            mem_req_valid         <= 1'b0;
            mem_req_we            <= 1'b0;
            mem_req_addr          <= '0;
            mem_req_wdata         <= '0;
            read_done             <= 1'b0;
            store_done            <= 1'b0;
            timeout_error         <= 1'b0;
            load_data_destination <= '0;
            data_from_load        <= '0;
            dest_q                <= '0;
            wait_cnt              <= '0;
        end else begin
            read_done  <= 1'b0;
            store_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Load has priority; a simultaneous store is dropped.
                    if (wait_load_signal) begin
                        state         <= S_ISSUE;
                        port_ready    <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= req_addr;
                        mem_req_wdata <= '0;
                        dest_q        <= load_destination;
                    end else if (store_request) begin
                        state         <= S_ISSUE;
                        port_ready    <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b1;
                        mem_req_addr  <= req_addr;
                        mem_req_wdata <= wrdata;
                        dest_q        <= load_destination;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_req_we) begin
                            store_done <= 1'b1;
                            port_ready <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        data_from_load        <= mem_rsp_rdata;
                        load_data_destination <= dest_q;
                        read_done             <= 1'b1;
                        state                 <= S_DONE;
                    end else if (wait_cnt != TIMEOUT_VAL) begin
                        // Keep waiting after a timeout; the flag only reports it.
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt + 1'b1 == TIMEOUT_VAL) begin
                            timeout_error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    port_ready <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    port_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vlane_mem_port.sv
module tb_vlane_mem_port;

    localparam int LW = 64;
    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          wait_load_signal;
    logic          store_request;
    logic [4:0]    load_destination;
    logic [LW-1:0] wrdata;
    logic [LW-1:0] indexed;
    logic [AW-1:0] base_address;
    logic          port_ready;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_wdata;
    logic          mem_rsp_valid;
    logic [LW-1:0] mem_rsp_rdata;
    logic          read_done;
    logic [4:0]    load_data_destination;
    logic [LW-1:0] data_from_load;
    logic          store_done;
    logic          timeout_error;

    int n_cmp = 0;
    int n_bad = 0;

    vlane_mem_port #(
        .LANES_DATA_WIDTH(LW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wait_load_signal(wait_load_signal),
        .store_request(store_request),
        .load_destination(load_destination),
        .wrdata(wrdata),
        .indexed(indexed),
        .base_address(base_address),
        .port_ready(port_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .read_done(read_done),
        .load_data_destination(load_data_destination),
        .data_from_load(data_from_load),
        .store_done(store_done),
        .timeout_error(timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          is_load;
        logic [AW-1:0] base;
        logic [LW-1:0] idx;
        logic [LW-1:0] wdata;
        logic [4:0]    dest;
        logic [LW-1:0] rdata;
        int            rdly;
        int            sdly;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wdata;
        logic          exp_we;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        chk({tag, ".port_ready_idle"}, port_ready, 1);
        wait_load_signal = v.is_load;
        store_request    = !v.is_load;
        base_address     = v.base;
        indexed          = v.idx;
        wrdata           = v.wdata;
        load_destination = v.dest;
        tick();
        wait_load_signal = 1'b0;
        store_request    = 1'b0;
        base_address     = $urandom;
        indexed          = {$urandom, $urandom};
        wrdata           = {$urandom, $urandom};
        load_destination = 5'($urandom);
        for (int k = 0; k <= v.rdly; k++) begin
            chk({tag, ".valid"}, mem_req_valid, 1);
            chk({tag, ".addr"}, mem_req_addr, v.exp_addr);
            chk({tag, ".we"}, mem_req_we, v.exp_we);
            chk({tag, ".wdata"}, mem_req_wdata, v.exp_wdata);
            chk({tag, ".port_ready_busy"}, port_ready, 0);
            mem_req_ready = (k == v.rdly);
            tick();
        end
        mem_req_ready = 1'b0;
        chk({tag, ".valid_after_hs"}, mem_req_valid, 0);
        if (!v.is_load) begin
            chk({tag, ".store_done"}, store_done, 1);
            chk({tag, ".port_ready_after_store"}, port_ready, 1);
            tick();
            chk({tag, ".store_done_pulse"}, store_done, 0);
        end else begin
            chk({tag, ".no_store_done"}, store_done, 0);
            for (int k = 0; k < v.sdly; k++) begin
                chk({tag, ".read_done_early"}, read_done, 0);
                tick();
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = v.rdata;
            tick();
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = {$urandom, $urandom};
            chk({tag, ".read_done"}, read_done, 1);
            chk({tag, ".dest"}, load_data_destination, v.dest);
            chk({tag, ".data"}, data_from_load, v.rdata);
            chk({tag, ".port_ready_done"}, port_ready, 0);
            tick();
            chk({tag, ".read_done_pulse"}, read_done, 0);
            chk({tag, ".port_ready_back"}, port_ready, 1);
            chk({tag, ".data_held"}, data_from_load, v.rdata);
            chk({tag, ".dest_held"}, load_data_destination, v.dest);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // is_load, base, idx, wdata, dest, rdata, rdly, sdly, exp_addr, exp_wdata, exp_we
        vecs[0] = '{1'b1, 32'h0000_1000, 64'h20, 64'h0, 5'd7, 64'hDEAD_BEEF_0000_0001,
                    0, 0, 32'h0000_1020, 64'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0040, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 5'd0, 64'h0,
                    3, 0, 32'h0000_0040, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1};
        vecs[2] = '{1'b1, 32'hFFFF_FFF8, 64'h10, 64'h0, 5'd31, 64'h0123_4567_89AB_CDEF,
                    1, 2, 32'h0000_0008, 64'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h2000_0000, 64'hFFFF_FFFF_0000_0100, 64'h1122_3344_5566_7788, 5'd3, 64'h0,
                    0, 0, 32'h2000_0100, 64'h1122_3344_5566_7788, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0010, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'h0000_0000_0000_CAFE,
                    2, 3, 32'h0000_0018, 64'h0, 1'b0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 64'h1, 64'h0000_0000_0000_00FF, 5'd12, 64'h0,
                    1, 0, 32'h0000_0000, 64'h0000_0000_0000_00FF, 1'b1};

        rst              = 1'b0;
        wait_load_signal = 1'b0;
        store_request    = 1'b0;
        load_destination = '0;
        wrdata           = '0;
        indexed          = '0;
        base_address     = '0;
        mem_req_ready    = 1'b0;
        mem_rsp_valid    = 1'b0;
        mem_rsp_rdata    = '0;

        // Reset state
        tick();
        tick();
        chk("rst.port_ready", port_ready, 1);
        chk("rst.valid", mem_req_valid, 0);
        chk("rst.we", mem_req_we, 0);
        chk("rst.addr", mem_req_addr, 0);
        chk("rst.wdata", mem_req_wdata, 0);
        chk("rst.read_done", read_done, 0);
        chk("rst.store_done", store_done, 0);
        chk("rst.timeout", timeout_error, 0);
        chk("rst.data", data_from_load, 0);
        chk("rst.dest", load_data_destination, 0);
        rst = 1'b1;
        tick();

        // Response while idle must be ignored
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h5555_5555_5555_5555;
        tick();
        mem_rsp_valid = 1'b0;
        chk("idle_rsp.read_done", read_done, 0);
        chk("idle_rsp.data", data_from_load, 0);
        chk("idle_rsp.port_ready", port_ready, 1);

        // Table-driven transactions
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end
        chk("table.no_timeout", timeout_error, 0);

        // Simultaneous load and store: load wins, store dropped
        wait_load_signal = 1'b1;
        store_request    = 1'b1;
        base_address     = 32'h0000_0300;
        indexed          = 64'h4;
        wrdata           = 64'h77;
        load_destination = 5'd9;
        tick();
        wait_load_signal = 1'b0;
        store_request    = 1'b0;
        chk("both.valid", mem_req_valid, 1);
        chk("both.we", mem_req_we, 0);
        chk("both.addr", mem_req_addr, 64'h304);
        chk("both.wdata", mem_req_wdata, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("both.store_done", store_done, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h0BAD_F00D_1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("both.read_done", read_done, 1);
        chk("both.dest", load_data_destination, 9);
        chk("both.store_done2", store_done, 0);
        tick();
        chk("both.port_ready", port_ready, 1);

        // Reset while in WAIT, then a late response
        wait_load_signal = 1'b1;
        base_address     = 32'h0000_0500;
        indexed          = 64'h0;
        load_destination = 5'd4;
        tick();
        wait_load_signal = 1'b0;
        mem_req_ready    = 1'b1;
        tick();
        mem_req_ready    = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstwait.port_ready", port_ready, 1);
        chk("rstwait.valid", mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFEED_FACE_FEED_FACE;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rstwait.read_done", read_done, 0);
        chk("rstwait.data", data_from_load, 0);
        chk("rstwait.port_ready2", port_ready, 1);
        tick();
        chk("rstwait.read_done2", read_done, 0);

        // Timeout with TIMEOUT_CYCLES = 4, then a late response
        wait_load_signal = 1'b1;
        base_address     = 32'h0000_0700;
        load_destination = 5'd21;
        tick();
        wait_load_signal = 1'b0;
        mem_req_ready    = 1'b1;
        tick();
        mem_req_ready    = 1'b0;
        chk("to.hs", timeout_error, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("to.before%0d", k), timeout_error, 0);
        end
        tick();
        chk("to.raised", timeout_error, 1);
        tick();
        tick();
        chk("to.sticky", timeout_error, 1);
        chk("to.no_read_done", read_done, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h0000_0000_0000_0ACE;
        tick();
        mem_rsp_valid = 1'b0;
        chk("to.late_read_done", read_done, 1);
        chk("to.late_data", data_from_load, 64'hACE);
        chk("to.late_dest", load_data_destination, 21);
        chk("to.still_set", timeout_error, 1);
        tick();
        chk("to.port_ready", port_ready, 1);
        chk("to.after_done", timeout_error, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("to.cleared_by_reset", timeout_error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
